// File: rtl/byte_word_loader_if.sv
// ----------------------------------------------------------------------------
// byte_word_loader_if
//   Groups the host-side control, byte-stream handshake and RAM write port of
//   byte_word_loader into one bundle.
//
//   Control : start, base_addr, num_words, abort      (host -> loader)
//   Stream  : byte_valid, byte_data (host -> loader), byte_ready (loader -> host)
//   RAM     : mem_we, mem_addr, mem_wdata             (loader -> RAM)
//   Status  : busy, done, checksum                    (loader -> host)
//
//   Modports: master = host/testbench side, slave = loader side.
// ----------------------------------------------------------------------------
interface byte_word_loader_if #(
    parameter int ADDR_W = 5
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   num_words;
    logic              abort;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic [31:0]       checksum;

    modport master (
        output start, base_addr, num_words, abort, byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata, busy, done, checksum
    );

    modport slave (
        input  start, base_addr, num_words, abort, byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata, busy, done, checksum
    );
endinterface

// File: rtl/byte_word_loader.sv
// ----------------------------------------------------------------------------
// byte_word_loader
//   Byte-serial receiver: assembles four bytes (little-endian, first byte in
//   [7:0]) into a 32-bit word and writes it to a word-addressed RAM with
//   address auto-increment (wrapping modulo 2^ADDR_W).
//
//   Ports:
//     clk    - system clock, rising edge
//     rst_n  - asynchronous active-low reset
//     bus    - byte_word_loader_if.slave (control, byte stream, RAM port, status)
//
//   Optional feature macro: LOADER_CHECKSUM_EN
//     defined   : checksum = XOR of all words written since the last start
//     undefined : checksum tied to zero, no accumulator register
// ----------------------------------------------------------------------------
module byte_word_loader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    byte_word_loader_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W:0]     r_remaining;
    logic [1:0]          r_cnt;
    logic [DATA_W-1:0]   r_asm;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;

    logic                w_start_ok;
    logic                w_take;
    logic                w_write;
    logic                w_last_word;

    // abort beats both a start in IDLE and any byte or write in progress
    assign w_start_ok  = (r_state == S_IDLE) && bus.start && !bus.abort;
    assign w_take      = (r_state == S_COLLECT) && bus.byte_valid && !bus.abort;
    assign w_write     = (r_state == S_WRITE) && !bus.abort;
    assign w_last_word = (r_remaining == {{ADDR_W{1'b0}}, 1'b1});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_next = (bus.num_words == '0) ? S_DONE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (bus.abort) begin
                    w_next = S_IDLE;
                end else if (w_take && (r_cnt == 2'd3)) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (bus.abort) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = w_last_word ? S_DONE : S_COLLECT;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // The RAM address/data registers are loaded on the 4th byte so they are
    // already valid during the single WRITE cycle and hold afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_cnt       <= '0;
            r_asm       <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            if (w_start_ok) begin
                r_addr      <= bus.base_addr;
                r_remaining <= bus.num_words;
                r_cnt       <= '0;
            end
            if (w_take) begin
                r_asm[{r_cnt, 3'b000} +: 8] <= bus.byte_data;
                r_cnt                       <= r_cnt + 2'd1;
                if (r_cnt == 2'd3) begin
                    r_mem_addr  <= r_addr;
                    r_mem_wdata <= {bus.byte_data, r_asm[DATA_W-9:0]};
                end
            end
            if (w_write) begin
                r_addr      <= r_addr + 1'b1;
                r_remaining <= r_remaining - 1'b1;
                r_cnt       <= '0;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_checksum <= '0;
        end else if (w_start_ok) begin
            r_checksum <= '0;
        end else if (w_write) begin
            r_checksum <= r_checksum ^ r_mem_wdata;
        end
    end

    assign bus.checksum = r_checksum;
`else
    assign bus.checksum = '0;
`endif

    assign bus.byte_ready = (r_state == S_COLLECT);
    assign bus.mem_we     = w_write;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = (r_state == S_DONE);

endmodule

// File: tb/tb_byte_word_loader.sv
// ----------------------------------------------------------------------------
// tb_byte_word_loader
//   Self-checking bench for byte_word_loader. A transaction-level reference
//   (byte queue, word index, words-left count) predicts every cycle's
//   handshake, write strobe, done pulse and checksum.
// ----------------------------------------------------------------------------
module tb_byte_word_loader;

    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    byte_word_loader_if #(.ADDR_W(AW)) bif ();

    byte_word_loader #(.ADDR_W(AW), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_collect, m_we, m_done, m_took;
    logic [AW-1:0] m_base, m_waddr;
    int          m_left, m_widx;
    logic [7:0]  m_q[$];
    logic [31:0] m_wdata, m_csum;

    int          n_we_seen, n_done_seen;
    logic [AW-1:0] last_addr;
    logic [31:0] last_data;

    logic [31:0] wq[$];

    function automatic bit m_busy();
        return m_collect || m_we || m_done;
    endfunction

    task automatic model_reset();
        m_collect = 0; m_we = 0; m_done = 0; m_took = 0;
        m_base = '0; m_waddr = '0; m_left = 0; m_widx = 0;
        m_q.delete();
        m_wdata = '0; m_csum = '0;
    endtask

    // One clock cycle: inputs already driven; check outputs, advance model.
    task automatic tick();
        bit exp_we, nc, nwe, nd;
        #1;
        exp_we = m_we && !bif.abort;
        check_eq("byte_ready", {31'b0, bif.byte_ready}, {31'b0, m_collect});
        check_eq("mem_we", {31'b0, bif.mem_we}, {31'b0, exp_we});
        if (exp_we) begin
            check_eq("mem_addr", {27'b0, bif.mem_addr}, {27'b0, m_waddr});
            check_eq("mem_wdata", bif.mem_wdata, m_wdata);
        end
        check_eq("done", {31'b0, bif.done}, {31'b0, m_done});
        check_eq("busy", {31'b0, bif.busy}, {31'b0, m_busy()});
        check_eq("checksum", bif.checksum, m_csum);
        if (bif.mem_we) begin
            n_we_seen++;
            last_addr = bif.mem_addr;
            last_data = bif.mem_wdata;
        end
        if (bif.done) n_done_seen++;

        nc = 0; nwe = 0; nd = 0; m_took = 0;
        if (!m_busy()) begin
            if (bif.start && !bif.abort) begin
                m_base = bif.base_addr;
                m_left = int'(bif.num_words);
                m_widx = 0;
                m_q.delete();
`ifdef LOADER_CHECKSUM_EN
                m_csum = '0;
`endif
                if (m_left == 0) nd = 1;
                else             nc = 1;
            end
        end else if (m_done) begin
            // done pulse completes regardless of abort
        end else if (bif.abort) begin
            m_q.delete();
        end else if (m_we) begin
`ifdef LOADER_CHECKSUM_EN
            m_csum = m_csum ^ m_wdata;
`endif
            m_widx++;
            m_left--;
            if (m_left == 0) nd = 1;
            else             nc = 1;
        end else begin
            nc = 1;
            if (bif.byte_valid) begin
                m_took = 1;
                m_q.push_back(bif.byte_data);
                if (m_q.size() == 4) begin
                    nc = 0;
                    nwe = 1;
                    m_wdata = {m_q[3], m_q[2], m_q[1], m_q[0]};
                    m_waddr = AW'((int'(m_base) + m_widx) % (1 << AW));
                    m_q.delete();
                end
            end
        end
        m_collect = nc; m_we = nwe; m_done = nd;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fill_random(input int n);
        wq.delete();
        for (int i = 0; i < n; i++) wq.push_back($urandom);
    endtask

    // Run one load of n words from wq. abort_at = byte index before which abort
    // is pulsed (-1: none). poke = pulse start mid-load (must be ignored).
    task automatic load(input logic [AW-1:0] base, input logic [AW:0] n,
                        input int gap_lo, input int gap_hi,
                        input int abort_at, input bit poke);
        int k;
        int tries;
        int gap;
        bit quit;
        k = 0;
        quit = 0;
        bif.base_addr  = base;
        bif.num_words  = n;
        bif.start      = 1'b1;
        bif.byte_valid = 1'b0;
        tick();
        bif.start     = 1'b0;
        bif.base_addr = AW'($urandom);
        bif.num_words = (AW+1)'($urandom);
        for (int w = 0; w < int'(n) && !quit; w++) begin
            for (int b = 0; b < 4 && !quit; b++) begin
                if (k == abort_at) begin
                    bif.byte_valid = 1'b0;
                    bif.abort      = 1'b1;
                    tick();
                    bif.abort = 1'b0;
                    quit = 1;
                end else begin
                    if (poke && w == int'(n) / 2 && b == 2) begin
                        bif.byte_valid = 1'b0;
                        bif.start      = 1'b1;
                        bif.base_addr  = AW'($urandom);
                        bif.num_words  = (AW+1)'($urandom_range(32, 0));
                        tick();
                        bif.start = 1'b0;
                    end
                    gap = $urandom_range(gap_hi, gap_lo);
                    for (int g = 0; g < gap; g++) begin
                        bif.byte_valid = 1'b0;
                        bif.byte_data  = 8'($urandom);
                        tick();
                    end
                    bif.byte_data  = wq[w][8*b +: 8];
                    bif.byte_valid = 1'b1;
                    tries = 0;
                    do begin
                        tick();
                        tries++;
                    end while (!m_took && tries < 40);
                    if (!m_took) begin
                        check_eq("byte_accept_timeout", 32'd0, 32'd1);
                        quit = 1;
                    end
                    k++;
                end
            end
        end
        // junk held valid through WRITE/DONE must never be consumed
        bif.byte_data = 8'hEE;
        tries = 0;
        while (m_busy() && tries < 20) begin
            tick();
            tries++;
        end
        if (m_busy()) check_eq("drain_timeout", 32'd0, 32'd1);
        bif.byte_valid = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int we0, d0;
        int n, ab;
        bif.start = 1'b0; bif.base_addr = '0; bif.num_words = '0; bif.abort = 1'b0;
        bif.byte_valid = 1'b0; bif.byte_data = '0;
        n_we_seen = 0; n_done_seen = 0; last_addr = '0; last_data = '0;
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", {31'b0, bif.busy}, 32'd0);
        check_eq("rst_ready", {31'b0, bif.byte_ready}, 32'd0);
        check_eq("rst_we", {31'b0, bif.mem_we}, 32'd0);
        check_eq("rst_done", {31'b0, bif.done}, 32'd0);
        check_eq("rst_addr", {27'b0, bif.mem_addr}, 32'd0);
        check_eq("rst_wdata", bif.mem_wdata, 32'd0);
        check_eq("rst_csum", bif.checksum, 32'd0);
        rst_n = 1'b1;
        tick();

        // single word, back-to-back bytes
        wq = '{32'h12345678};
        we0 = n_we_seen; d0 = n_done_seen;
        load(5'd3, 6'd1, 0, 0, -1, 0);
        check_eq("single_we_cnt", n_we_seen - we0, 32'd1);
        check_eq("single_done_cnt", n_done_seen - d0, 32'd1);
        check_eq("single_addr", {27'b0, last_addr}, 32'd3);
        check_eq("single_data", last_data, 32'h12345678);

        // throttled, wrapping address
        wq = '{32'h1, 32'h2, 32'h3};
        we0 = n_we_seen;
        load(5'd30, 6'd3, 8, 8, -1, 0);
        check_eq("wrap_we_cnt", n_we_seen - we0, 32'd3);
        check_eq("wrap_last_addr", {27'b0, last_addr}, 32'd0);
        check_eq("wrap_last_data", last_data, 32'h3);

        // abort after 2 bytes of word 2 of a 4-word load
        fill_random(4);
        we0 = n_we_seen; d0 = n_done_seen;
        load(5'd12, 6'd4, 0, 1, 6, 0);
        check_eq("abort_we_cnt", n_we_seen - we0, 32'd1);
        check_eq("abort_done_cnt", n_done_seen - d0, 32'd0);
        wq = '{32'hCAFEF00D};
        load(5'd0, 6'd1, 0, 0, -1, 0);
        check_eq("post_abort_addr", {27'b0, last_addr}, 32'd0);
        check_eq("post_abort_data", last_data, 32'hCAFEF00D);

        // abort landing in the WRITE cycle suppresses the strobe
        fill_random(2);
        we0 = n_we_seen;
        load(5'd5, 6'd2, 0, 0, 4, 0);
        check_eq("abort_write_we_cnt", n_we_seen - we0, 32'd0);

        // zero length
        we0 = n_we_seen; d0 = n_done_seen;
        wq.delete();
        load(5'd7, 6'd0, 0, 0, -1, 0);
        check_eq("zero_we_cnt", n_we_seen - we0, 32'd0);
        check_eq("zero_done_cnt", n_done_seen - d0, 32'd1);

        // start pulsed mid-load is ignored
        fill_random(4);
        we0 = n_we_seen;
        load(5'd10, 6'd4, 0, 2, -1, 1);
        check_eq("poke_we_cnt", n_we_seen - we0, 32'd4);
        check_eq("poke_last_addr", {27'b0, last_addr}, 32'd13);

        // checksum
        wq = '{32'hFFFF0000, 32'h0F0F0F0F};
        load(5'd20, 6'd2, 0, 1, -1, 0);
`ifdef LOADER_CHECKSUM_EN
        check_eq("csum_value", bif.checksum, 32'hF0F00F0F);
`else
        check_eq("csum_value", bif.checksum, 32'h0);
`endif

        // full RAM, wraps back to base
        fill_random(32);
        we0 = n_we_seen;
        load(5'd17, 6'd32, 0, 1, -1, 0);
        check_eq("full_we_cnt", n_we_seen - we0, 32'd32);
        check_eq("full_last_addr", {27'b0, last_addr}, 32'd16);

        // randomized loads
        for (int it = 0; it < 24; it++) begin
            n = $urandom_range(5, 1);
            fill_random(n);
            ab = ($urandom_range(3, 0) == 0) ? $urandom_range(4 * n - 1, 0) : -1;
            load(AW'($urandom), (AW+1)'(n), 0, $urandom_range(3, 0), ab, 1'($urandom));
        end

        // reset in the middle of a word
        bif.base_addr = 5'd9; bif.num_words = 6'd2; bif.start = 1'b1;
        tick();
        bif.start = 1'b0;
        bif.byte_data = 8'hAA; bif.byte_valid = 1'b1;
        tick();
        bif.byte_data = 8'hBB;
        tick();
        bif.byte_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_busy", {31'b0, bif.busy}, 32'd0);
        check_eq("midrst_ready", {31'b0, bif.byte_ready}, 32'd0);
        check_eq("midrst_addr", {27'b0, bif.mem_addr}, 32'd0);
        check_eq("midrst_wdata", bif.mem_wdata, 32'd0);
        check_eq("midrst_csum", bif.checksum, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        fill_random(2);
        load(5'd1, 6'd2, 0, 1, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
